// File: rtl/spi_flash_master_pkg.sv
// rtl/spi_flash_master_pkg.sv - opcodes, FSM state type and opcode helper for spi_flash_master
package spi_flash_pkg;

   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PROG = 8'h02;
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_WRDI = 8'h04;

   typedef enum logic [3:0] {
      ST_IDLE,
`ifdef SPI_FLASH_AUTO_WREN_EN
      ST_WREN,
      ST_WGAP,
`endif
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_RGAP,
      ST_RDATA,
      ST_END,
      ST_ACK
   } state_t;

   function automatic logic [7:0] cmd_opcode(input logic we);
      return we ? OP_PROG : OP_READ;
   endfunction

endpackage

// File: rtl/spi_flash_master_if.sv
// rtl/spi_flash_master_if.sv - Wishbone-B3 single-byte bus between CPU/debug master and spi_flash_master
interface spi_flash_master_if;
   logic [23:0] wb_adr_i;
   logic [7:0]  wb_dat_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [7:0]  wb_dat_o;
   logic        wb_ack_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/spi_flash_master_shifter.sv
// rtl/spi_flash_master_shifter.sv - spi_byte_shifter: 8-bit MSB-first SPI shift register
module spi_byte_shifter (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       i_load,
   input  logic [7:0] i_data,
   input  logic       i_shift,
   input  logic       i_miso,
   input  logic       i_last,
   output logic       o_msb,
   output logic [7:0] o_data,
   output logic       o_done
);
   logic [7:0] r_sr;

   // Load wins over shift so the next byte replaces the finished one on its last falling edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         r_sr <= 8'h00;
      else if (i_load)
         r_sr <= i_data;
      else if (i_shift)
         r_sr <= {r_sr[6:0], i_miso};
   end

   assign o_msb  = r_sr[7];
   assign o_data = r_sr;
   assign o_done = i_shift & i_last;
endmodule

// File: rtl/spi_flash_master.sv
// rtl/spi_flash_master.sv - Wishbone-to-SPI mode-0 flash bridge; SPI_FLASH_AUTO_WREN_EN adds a 0x06 frame before writes
module spi_flash_master
   import spi_flash_pkg::*;
#(
   parameter int CLK_DIV        = 4,
   parameter int RD_GAP_CYCLES  = 16,
   parameter int SS_IDLE_CYCLES = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   spi_flash_master_if.slave   wb,
   output logic                sck_o,
   output logic                ss_o,
   output logic                mosi_o,
   input  logic                miso_i,
   output logic                busy_o
);
   localparam logic [15:0] DIV_LD  = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LD  = 16'(RD_GAP_CYCLES);
   localparam logic [15:0] IDLE_LD = 16'(SS_IDLE_CYCLES);

   state_t      r_state;
   logic [15:0] r_div, r_gap, r_idle;
   logic [2:0]  r_bit_cnt;
   logic [1:0]  r_byte_cnt;
   logic        r_sck, r_ss, r_we, r_abort, r_busy, r_ack;
   logic [23:0] r_adr;
   logic [7:0]  r_dat, r_rdat;

   logic       w_accept, w_shifting, w_tick, w_fall, w_done, w_msb, w_load, w_wgap_exit;
   logic [7:0] w_load_data, w_sr;

   assign w_accept = (r_state == ST_IDLE) && wb.wb_cyc_i && wb.wb_stb_i && (r_idle == 16'd0);
   assign w_tick   = (r_div == 16'd0);
   assign w_fall   = w_shifting && w_tick && r_sck;
`ifdef SPI_FLASH_AUTO_WREN_EN
   assign w_wgap_exit = (r_state == ST_WGAP) && r_ss && (r_idle == 16'd0);
`else
   assign w_wgap_exit = 1'b0;
`endif

   always_comb begin
      w_shifting = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                   (r_state == ST_WDATA) || (r_state == ST_RDATA);
`ifdef SPI_FLASH_AUTO_WREN_EN
      if (r_state == ST_WREN) w_shifting = 1'b1;
`endif
   end

   always_comb begin
      w_load      = 1'b0;
      w_load_data = 8'h00;
      case (r_state)
         ST_IDLE: if (w_accept) begin
            w_load = 1'b1;
`ifdef SPI_FLASH_AUTO_WREN_EN
            w_load_data = wb.wb_we_i ? OP_WREN : OP_READ;
`else
            w_load_data = cmd_opcode(wb.wb_we_i);
`endif
         end
         ST_CMD: if (w_done) begin
            w_load      = 1'b1;
            w_load_data = r_adr[23:16];
         end
         ST_ADDR: if (w_done) begin
            w_load      = (r_byte_cnt != 2'd0) || r_we;
            w_load_data = (r_byte_cnt == 2'd2) ? r_adr[15:8] :
                          (r_byte_cnt == 2'd1) ? r_adr[7:0]  : r_dat;
         end
         default: if (w_wgap_exit) begin
            w_load      = 1'b1;
            w_load_data = OP_PROG;
         end
      endcase
   end

   spi_byte_shifter u_shifter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_load  (w_load),
      .i_data  (w_load_data),
      .i_shift (w_fall),
      .i_miso  (miso_i),
      .i_last  (r_bit_cnt == 3'd0),
      .o_msb   (w_msb),
      .o_data  (w_sr),
      .o_done  (w_done)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ST_IDLE;
         r_div      <= 16'd0;
         r_gap      <= 16'd0;
         r_idle     <= 16'd0;
         r_bit_cnt  <= 3'd7;
         r_byte_cnt <= 2'd0;
         r_sck      <= 1'b0;
         r_ss       <= 1'b1;
         r_we       <= 1'b0;
         r_abort    <= 1'b0;
         r_busy     <= 1'b0;
         r_ack      <= 1'b0;
         r_adr      <= 24'h0;
         r_dat      <= 8'h00;
         r_rdat     <= 8'h00;
      end else begin
         r_ack <= 1'b0;
         if (r_idle != 16'd0) r_idle <= r_idle - 16'd1;
         if (r_busy && !wb.wb_cyc_i) r_abort <= 1'b1;

         // A frame opens by dropping ss one cycle ahead of the first rising edge
         if (w_shifting) begin
            if (!w_tick)
               r_div <= r_div - 16'd1;
            else if (!r_sck && r_ss)
               r_ss <= 1'b0;
            else begin
               r_div <= DIV_LD;
               r_sck <= ~r_sck;
               if (r_sck) r_bit_cnt <= r_bit_cnt - 3'd1;
            end
         end

         case (r_state)
            ST_IDLE: if (w_accept) begin
               r_adr     <= wb.wb_adr_i;
               r_dat     <= wb.wb_dat_i;
               r_we      <= wb.wb_we_i;
               r_busy    <= 1'b1;
               r_abort   <= 1'b0;
               r_div     <= DIV_LD;
               r_bit_cnt <= 3'd7;
`ifdef SPI_FLASH_AUTO_WREN_EN
               r_state   <= wb.wb_we_i ? ST_WREN : ST_CMD;
`else
               r_state   <= ST_CMD;
`endif
            end
`ifdef SPI_FLASH_AUTO_WREN_EN
            ST_WREN: if (w_done) r_state <= ST_WGAP;
            ST_WGAP: begin
               if (!r_ss) begin
                  if (!w_tick) r_div <= r_div - 16'd1;
                  else begin
                     r_ss   <= 1'b1;
                     r_idle <= IDLE_LD;
                  end
               end else if (w_wgap_exit) begin
                  r_div   <= DIV_LD;
                  r_state <= ST_CMD;
               end
            end
`endif
            ST_CMD: if (w_done) begin
               r_byte_cnt <= 2'd2;
               r_state    <= ST_ADDR;
            end
            ST_ADDR: if (w_done) begin
               if (r_byte_cnt != 2'd0) r_byte_cnt <= r_byte_cnt - 2'd1;
               else if (r_we) r_state <= ST_WDATA;
               else begin
                  r_gap   <= GAP_LD;
                  r_state <= ST_RGAP;
               end
            end
            ST_WDATA: if (w_done) r_state <= ST_END;
            ST_RGAP: begin
               if (r_gap != 16'd0) r_gap <= r_gap - 16'd1;
               else begin
                  r_div   <= DIV_LD;
                  r_state <= ST_RDATA;
               end
            end
            ST_RDATA: if (w_done) r_state <= ST_END;
            ST_END: begin
               if (!w_tick) r_div <= r_div - 16'd1;
               else begin
                  r_ss    <= 1'b1;
                  r_idle  <= IDLE_LD;
                  r_state <= ST_ACK;
               end
            end
            ST_ACK: begin
               r_ack <= !r_abort && wb.wb_cyc_i;
               if (!r_we && !r_abort && wb.wb_cyc_i) r_rdat <= w_sr;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign sck_o       = r_sck;
   assign ss_o        = r_ss;
   assign mosi_o      = w_shifting && (r_state != ST_RDATA) && w_msb;
   assign busy_o      = r_busy;
   assign wb.wb_ack_o = r_ack;
   assign wb.wb_dat_o = r_rdat;
endmodule

// File: tb/tb_spi_flash_master.sv
// tb/tb_spi_flash_master.sv - scoreboard bench for spi_flash_master with an SPI memory responder
module tb_spi_flash_master;
   import spi_flash_pkg::*;

   localparam int CLK_DIV = 4;
   localparam int RD_GAP  = 16;
   localparam int SS_IDLE = 4;
   localparam int TMO     = 3000;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b1;
   logic miso_i = 1'b0;
   logic sck_o, ss_o, mosi_o, busy_o;

   spi_flash_master_if wb();

   spi_flash_master #(.CLK_DIV(CLK_DIV), .RD_GAP_CYCLES(RD_GAP), .SS_IDLE_CYCLES(SS_IDLE)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .wb     (wb),
      .sck_o  (sck_o),
      .ss_o   (ss_o),
      .mosi_o (mosi_o),
      .miso_i (miso_i),
      .busy_o (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { int nbits; logic [39:0] val; } frame_t;
   frame_t     exp_frames[$];
   logic [7:0] exp_acks[$];
   logic [7:0] mem [logic [23:0]];
   logic [7:0] last_dat = 8'h00;
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mem_rd(input logic [23:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   // Responder + monitor: decodes frames, drives MISO after each rising edge, checks timing and acks
   logic        prev_sck = 1'b0, prev_ss = 1'b1, prev_ack = 1'b0, prev_mosi = 1'b0;
   bit          first_frame = 1'b1;
   int          nbits = 0, since = 0, low_cnt = 0, high_cnt = 0;
   logic [39:0] sh = '0;
   logic [7:0]  op = 8'h00, rb;
   logic [23:0] fadr = '0;
   frame_t      f;

   always @(negedge clk_i) begin
      if (ss_o && !prev_ss) begin
         if (exp_frames.size() == 0) chk("unexpected_frame", 1, 0);
         else begin
            f = exp_frames.pop_front();
            if (f.nbits < 0) chk("aborted_frame_truncated", 64'(nbits < 40), 1);
            else begin
               chk("frame_bits", 64'(nbits), 64'(f.nbits));
               chk("frame_mosi", sh, f.val);
            end
         end
         if (nbits == 40 && op == OP_PROG) mem[fadr] = sh[7:0];
      end
      if (!ss_o && prev_ss) begin
         if (!first_frame) chk("ss_idle_gap", 64'(high_cnt >= SS_IDLE), 1);
         first_frame = 1'b0;
         nbits = 0; sh = '0; since = 0; miso_i = 1'b0;
      end else if (!ss_o) since++;
      if (ss_o) high_cnt++; else high_cnt = 0;
      if (!ss_o && sck_o && !prev_sck) begin
         if (nbits == 0) chk("ss_lead_sck", 64'(since), 1);
         if (nbits == 32 && op == OP_READ) chk("rd_gap_sck_low", 64'(low_cnt >= RD_GAP), 1);
         if (nbits >= 32 && op == OP_READ) begin
            rb = mem_rd(fadr);
            miso_i = rb[7 - (nbits - 32)];
         end
         sh = {sh[38:0], mosi_o};
         nbits++;
         if (nbits == 8)  op   = sh[7:0];
         if (nbits == 32) fadr = sh[23:0];
      end
      if (!ss_o && sck_o && prev_sck && (mosi_o !== prev_mosi)) chk("mosi_stable_sck_high", mosi_o, prev_mosi);
      if (sck_o) low_cnt = 0; else low_cnt++;
      if (wb.wb_ack_o) begin
         chk("ack_single_cycle", prev_ack, 0);
         if (exp_acks.size() == 0) chk("unexpected_ack", 1, 0);
         else chk("ack_data", wb.wb_dat_o, exp_acks.pop_front());
      end
      prev_sck = sck_o; prev_ss = ss_o; prev_ack = wb.wb_ack_o; prev_mosi = mosi_o;
   end

   task automatic push_write(input logic [23:0] a, input logic [7:0] d);
      frame_t fr;
`ifdef SPI_FLASH_AUTO_WREN_EN
      fr.nbits = 8;  fr.val = {32'h0, OP_WREN};
      exp_frames.push_back(fr);
`endif
      fr.nbits = 40; fr.val = {OP_PROG, a, d};
      exp_frames.push_back(fr);
      exp_acks.push_back(last_dat);
   endtask

   task automatic push_read(input logic [23:0] a, input logic [7:0] d, input bit acked);
      frame_t fr;
      fr.nbits = 40; fr.val = {OP_READ, a, 8'h00};
      exp_frames.push_back(fr);
      if (acked) begin
         exp_acks.push_back(d);
         last_dat = d;
      end
   endtask

   task automatic drive(input logic we, input logic [23:0] a, input logic [7:0] d);
      wb.wb_adr_i = a; wb.wb_dat_i = d; wb.wb_we_i = we;
      wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
   endtask

   task automatic wait_ack(input string name);
      int n = 0;
      while (!wb.wb_ack_o && n < TMO) begin @(negedge clk_i); n++; end
      if (n >= TMO) chk(name, 0, 1);
      wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
   endtask

   task automatic access(input logic we, input logic [23:0] a, input logic [7:0] d);
      @(negedge clk_i);
      drive(we, a, d);
      @(negedge clk_i);
      wait_ack("ack_timeout");
   endtask

   task automatic wait_ss(input logic lvl, input string name);
      int n = 0;
      while (ss_o !== lvl && n < TMO) begin @(negedge clk_i); n++; end
      if (n >= TMO) chk(name, 0, 1);
   endtask

   task automatic wait_bits(input int b, input string name);
      int n = 0;
      while (nbits < b && n < TMO) begin @(negedge clk_i); n++; end
      if (n >= TMO) chk(name, 0, 1);
   endtask

   initial begin
      frame_t fr;
      int n;
      wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_we_i = 1'b0;
      wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
      #1 rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_sck", sck_o, 0);
      chk("rst_ss", ss_o, 1);
      chk("rst_mosi", mosi_o, 0);
      chk("rst_ack", wb.wb_ack_o, 0);
      chk("rst_dat", wb.wb_dat_o, 0);
      chk("rst_busy", busy_o, 0);
      rst_ni = 1'b1;

      push_write(24'h012345, 8'hA5);         access(1'b1, 24'h012345, 8'hA5);
      push_read(24'h012345, 8'hA5, 1'b1);    access(1'b0, 24'h012345, 8'h00);
      push_read(24'hFFFFFF, 8'h00, 1'b1);    access(1'b0, 24'hFFFFFF, 8'h00);

      fr.nbits = -1; fr.val = '0;
      exp_frames.push_back(fr);
      @(negedge clk_i);
      drive(1'b0, 24'h000020, 8'h00);
      wait_ss(1'b0, "t4_frame_start_timeout");
      @(negedge clk_i);
      wait_bits(20, "t4_addr_timeout");
      rst_ni = 1'b0;
      #1;
      chk("midframe_rst_ss", ss_o, 1);
      chk("midframe_rst_sck", sck_o, 0);
      chk("midframe_rst_busy", busy_o, 0);
      wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      last_dat = 8'h00;
      push_write(24'h000010, 8'h5A);         access(1'b1, 24'h000010, 8'h5A);
      push_read(24'h000010, 8'h5A, 1'b1);    access(1'b0, 24'h000010, 8'h00);

      push_read(24'h012345, 8'hA5, 1'b0);
      @(negedge clk_i);
      drive(1'b0, 24'h012345, 8'h00);
      wait_ss(1'b0, "t5_frame_start_timeout");
      @(negedge clk_i);
      wait_bits(2, "t5_cmd_timeout");
      wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
      wait_ss(1'b1, "t5_frame_end_timeout");
      push_read(24'h012345, 8'hA5, 1'b1);
      drive(1'b0, 24'h012345, 8'h00);
      n = 0;
      do begin @(negedge clk_i); n++; end while (!busy_o && n < TMO);
      chk("reaccept_after_idle", 64'(n >= SS_IDLE + 1), 1);
      wait_ack("t5_ack_timeout");

      push_write(24'h000001, 8'h3C);         access(1'b1, 24'h000001, 8'h3C);
      push_read(24'h000001, 8'h3C, 1'b1);    access(1'b0, 24'h000001, 8'h00);

      repeat (20) @(negedge clk_i);
      chk("frames_drained", 64'(exp_frames.size()), 0);
      chk("acks_drained", 64'(exp_acks.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule
